// File: rtl/btn_conditioner.sv
// Button front end: 2-flop sync, per-button debounce, opposing-direction
// arbitration and a frame-aligned hold/auto-repeat strobe generator per direction.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY_FRAMES = 20,
  parameter int unsigned REPEAT_RATE_FRAMES  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic in_up,
  input  logic in_down,
  input  logic in_left,
  input  logic in_right,
  output logic lvl_up,
  output logic lvl_down,
  output logic lvl_left,
  output logic lvl_right,
  output logic step_up,
  output logic step_down,
  output logic step_left,
  output logic step_right,
  output logic any_pressed
);

  localparam int unsigned DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FMAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                 REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int unsigned FCW  = $clog2(FMAX + 1);

  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FCW-1:0] DELAY_LOAD = FCW'(REPEAT_DELAY_FRAMES - 1);
  localparam logic [FCW-1:0] RATE_LOAD  = FCW'(REPEAT_RATE_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_DELAY, ST_REPEAT} state_t;

  // Bit order throughout: {right, left, down, up}
  logic [3:0] raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] lvl;
  logic [3:0] req;
  logic [3:0] force_idle;
  logic [3:0] step;
  logic       any_q;

  assign raw = {in_right, in_left, in_down, in_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Both buttons of an axis held cancels that axis entirely.
  assign force_idle[1:0] = {2{&lvl[1:0]}};
  assign force_idle[3:2] = {2{&lvl[3:2]}};
  assign req             = lvl & ~force_idle;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    logic [DCW-1:0] db_cnt_q, db_cnt_d;
    logic           lvl_q, lvl_d;
    state_t         state_q, state_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           step_q, step_d;

    always_comb begin
      db_cnt_d = db_cnt_q;
      lvl_d    = lvl_q;
      if (sync2_q[g] == lvl_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        lvl_d    = ~lvl_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      step_d  = 1'b0;
      if (force_idle[g]) begin
        state_d = ST_IDLE;
      end else if (frame_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (req[g]) state_d = ST_FIRST;
          end
          ST_FIRST: begin
            if (req[g]) begin
              step_d  = 1'b1;
              fcnt_d  = DELAY_LOAD;
              state_d = ST_DELAY;
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_DELAY: begin
            if (!req[g]) begin
              state_d = ST_IDLE;
            end else if (fcnt_q == '0) begin
              step_d  = 1'b1;
              fcnt_d  = RATE_LOAD;
              state_d = ST_REPEAT;
            end else begin
              fcnt_d = fcnt_q - 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!req[g]) begin
              state_d = ST_IDLE;
            end else if (fcnt_q == '0) begin
              step_d = 1'b1;
              fcnt_d = RATE_LOAD;
            end else begin
              fcnt_d = fcnt_q - 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        db_cnt_q <= '0;
        lvl_q    <= 1'b0;
        state_q  <= ST_IDLE;
        fcnt_q   <= '0;
        step_q   <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        lvl_q    <= lvl_d;
        state_q  <= state_d;
        fcnt_q   <= fcnt_d;
        step_q   <= step_d;
      end
    end

    assign lvl[g]  = lvl_q;
    assign step[g] = step_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_q <= 1'b0;
    else     any_q <= |lvl;
  end

  assign lvl_up      = lvl[0];
  assign lvl_down    = lvl[1];
  assign lvl_left    = lvl[2];
  assign lvl_right   = lvl[3];
  assign step_up     = step[0];
  assign step_down   = step[1];
  assign step_left   = step[2];
  assign step_right  = step[3];
  assign any_pressed = any_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed presses push expected
// (frame, strobe vector) items; a monitor pops one per observed strobe cycle.
module tb_btn_conditioner;

  localparam int unsigned FP = 16;  // clk cycles per frame

  logic clk = 1'b0;
  logic rst;
  logic frame_tick;
  logic in_up, in_down, in_left, in_right;
  logic lvl_up, lvl_down, lvl_left, lvl_right;
  logic step_up, step_down, step_left, step_right;
  logic any_pressed;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_FRAMES (20),
    .REPEAT_RATE_FRAMES  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .in_up       (in_up),
    .in_down     (in_down),
    .in_left     (in_left),
    .in_right    (in_right),
    .lvl_up      (lvl_up),
    .lvl_down    (lvl_down),
    .lvl_left    (lvl_left),
    .lvl_right   (lvl_right),
    .step_up     (step_up),
    .step_down   (step_down),
    .step_left   (step_left),
    .step_right  (step_right),
    .any_pressed (any_pressed)
  );

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000;

  typedef struct {
    int unsigned tick;
    logic [3:0]  vec;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned tick_cnt = 0;
  int unsigned t0;
  logic [3:0]  step_vec;
  logic        seen;

  assign step_vec = {step_right, step_left, step_down, step_up};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned tick, input logic [3:0] vec);
    exp_t e;
    e.tick = tick;
    e.vec  = vec;
    sb.push_back(e);
  endtask

  // Inputs changed before this call are debounced well before the first tick.
  task automatic run_frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      repeat (8) @(negedge clk);
      tick_cnt++;
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic set_btn(input logic [3:0] v);
    {in_right, in_left, in_down, in_up} = v;
  endtask

  // Monitor: every cycle with any strobe must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && step_vec != 4'b0000) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_step: got %b at tick %0d expected none", step_vec, tick_cnt);
        end else begin
          e = sb.pop_front();
          chk("step_tick", tick_cnt, e.tick);
          chk("step_vec", {28'd0, step_vec}, {28'd0, e.vec});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    frame_tick = 1'b0;
    set_btn(4'b0000);
    repeat (3) @(negedge clk);
    chk("reset_lvl",  {28'd0, lvl_right, lvl_left, lvl_down, lvl_up}, 32'd0);
    chk("reset_step", {28'd0, step_vec}, 32'd0);
    chk("reset_any",  {31'd0, any_pressed}, 32'd0);
    rst = 1'b0;
    run_frames(2);

    // Debounce latency on right, then a single strobe one frame after it is seen.
    @(negedge clk);
    set_btn(RT);
    repeat (5) @(posedge clk);
    #1 chk("db_lat_before", {31'd0, lvl_right}, 32'd0);
    @(posedge clk);
    #1 chk("db_lat_edge", {31'd0, lvl_right}, 32'd1);
    chk("any_reg_lag", {31'd0, any_pressed}, 32'd0);
    @(posedge clk);
    #1 chk("any_reg", {31'd0, any_pressed}, 32'd1);
    t0 = tick_cnt;
    push(t0 + 2, RT);
    run_frames(2);
    set_btn(4'b0000);
    run_frames(3);
    chk("right_released", {31'd0, lvl_right}, 32'd0);

    // Bounce: toggling every 3 cycles never survives a 4-cycle debounce.
    seen = 1'b0;
    for (int unsigned i = 0; i < 50; i++) begin
      in_up = ~in_up;
      repeat (3) begin
        @(negedge clk);
        if (lvl_up) seen = 1'b1;
      end
    end
    in_up = 1'b0;
    repeat (10) @(negedge clk);
    chk("bounce_lvl_seen", {31'd0, seen}, 32'd0);
    run_frames(3);

    // Short press fully inside a frame: level pulses but no strobe.
    @(negedge clk);
    in_down = 1'b1;
    repeat (8) @(negedge clk);
    chk("short_lvl_hi", {31'd0, lvl_down}, 32'd1);
    in_down = 1'b0;
    repeat (8) @(negedge clk);
    chk("short_lvl_lo", {31'd0, lvl_down}, 32'd0);
    run_frames(3);

    // Hold left 40 frames: first, +20, then every 4.
    set_btn(LF);
    t0 = tick_cnt;
    push(t0 + 2, LF); push(t0 + 22, LF); push(t0 + 26, LF);
    push(t0 + 30, LF); push(t0 + 34, LF); push(t0 + 38, LF);
    run_frames(40);
    set_btn(4'b0000);
    run_frames(2);

    // Up repeating, down joins: axis silenced; down released: restart via FIRST.
    set_btn(UP);
    t0 = tick_cnt;
    push(t0 + 2, UP); push(t0 + 22, UP); push(t0 + 26, UP);
    run_frames(27);
    set_btn(UP | DN);
    run_frames(5);
    chk("conflict_lvls", {30'd0, lvl_down, lvl_up}, 32'd3);
    set_btn(UP);
    push(t0 + 34, UP); push(t0 + 54, UP);
    run_frames(22);
    set_btn(4'b0000);
    run_frames(2);

    // Diagonal: both axes strobe together.
    set_btn(UP | RT);
    t0 = tick_cnt;
    push(t0 + 2, UP | RT); push(t0 + 22, UP | RT); push(t0 + 26, UP | RT);
    run_frames(13);
    chk("diag_any_mid", {31'd0, any_pressed}, 32'd1);
    run_frames(13);
    chk("diag_any_end", {31'd0, any_pressed}, 32'd1);
    set_btn(4'b0000);
    run_frames(2);
    chk("diag_any_off", {31'd0, any_pressed}, 32'd0);

    // Reset during a REPEAT strobe, then full restart from IDLE.
    set_btn(LF);
    t0 = tick_cnt;
    push(t0 + 2, LF); push(t0 + 22, LF); push(t0 + 26, LF);
    run_frames(25);
    repeat (8) @(negedge clk);
    tick_cnt++;
    frame_tick = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_step", {28'd0, step_vec}, 32'd0);
    chk("rst_lvl",  {28'd0, lvl_right, lvl_left, lvl_down, lvl_up}, 32'd0);
    chk("rst_any",  {31'd0, any_pressed}, 32'd0);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("rst_db_before", {31'd0, lvl_left}, 32'd0);
    @(posedge clk);
    #1 chk("rst_db_edge", {31'd0, lvl_left}, 32'd1);
    t0 = tick_cnt;
    push(t0 + 2, LF); push(t0 + 22, LF);
    run_frames(22);
    set_btn(4'b0000);
    run_frames(3);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Sits directly upstream of the moving_car stage. Takes the four raw push-button inputs (up/down/left/right) and produces clean, frame-aligned movement strobes for the car logic.
- Processing chain: 2-flop synchronisation, per-button debounce, then a per-direction hold/auto-repeat state machine that only emits strobes on a frame tick.
- Opposing-direction conflicts are resolved here, so moving_car sees at most one strobe per axis per frame.

Parameters:
- DEBOUNCE_CYCLES, 500000: pixclk cycles a synchronised input must hold a new value before the debounced level changes.
- REPEAT_DELAY_FRAMES, 20: frames a button must stay held after its first strobe before auto-repeat starts.
- REPEAT_RATE_FRAMES, 4: frame period between auto-repeat strobes.

Ports:
- clk  input  1  pixel clock (pixclk domain).
- rst  input  1  asynchronous, active-high reset.
- frame_tick  input  1  one-cycle pulse, asserted once per frame (vga_out position 0,0).
- in_up, in_down, in_left, in_right  input  1 each  raw asynchronous buttons, active-high.
- lvl_up, lvl_down, lvl_left, lvl_right  output  1 each  debounced levels.
- step_up, step_down, step_left, step_right  output  1 each  one-cycle move strobes, only in the cycle after frame_tick.
- any_pressed  output  1  OR of the four debounced levels, registered.

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; sync flops, debounce counters and frame counters 0; all FSMs in IDLE. Reset mid-operation aborts any pending strobe immediately.
- Synchronisation: each raw input passes through 2 flops.
- Debounce, per button:
  - Counter clears whenever the sync value equals the current lvl_*.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, lvl_* toggles and the counter clears.
  - Latency from a stable edge at the pin to the lvl_* change is DEBOUNCE_CYCLES+2 cycles.
  - Counter width is clog2(DEBOUNCE_CYCLES); it must never wrap.
- Axis arbitration: if lvl_up and lvl_down are both 1, the vertical effective request is 0 and both vertical FSMs are forced to IDLE. The same rule applies to left/right. Axes are independent, so diagonal strobes are allowed.
- Per-direction FSM (req = arbitrated effective level), state changes evaluated only on frame_tick:
  - IDLE: req=1 -> FIRST.
  - FIRST: emit strobe; load frame counter with REPEAT_DELAY_FRAMES-1; go to DELAY. If req=0 -> IDLE, no strobe.
  - DELAY: req=0 -> IDLE. Counter=0 -> emit strobe, load REPEAT_RATE_FRAMES-1, go to REPEAT. Otherwise decrement.
  - REPEAT: req=0 -> IDLE. Counter=0 -> emit strobe, reload REPEAT_RATE_FRAMES-1. Otherwise decrement.
- Strobe timing:
  - A press seen at frame tick N produces its first strobe at the frame_tick at which the FSM is in FIRST, i.e. frame N+1 (one frame of latency).
  - step_* is registered and high for exactly the one clk cycle after that frame_tick.
- Timing boundaries:
  - A release between ticks is seen at the next tick: no strobe is issued, the FSM goes to IDLE.
  - A press and release entirely within one frame gives no strobe if lvl_* is already 0 at the tick.
- Steady-state rate: after the first strobe, the next strobe comes REPEAT_DELAY_FRAMES frames later, then one every REPEAT_RATE_FRAMES frames.
- Parameter edge cases:
  - REPEAT_RATE_FRAMES=1: one strobe per frame.
  - Frame counter width is clog2(max(REPEAT_DELAY_FRAMES, REPEAT_RATE_FRAMES)+1).
- frame_tick asserted in consecutive cycles: each cycle is treated as a separate frame (no filtering).

Test Plan:
- Reset, then hold in_right high for 600000 cycles (DEBOUNCE_CYCLES=500000) -> lvl_right rises at cycle 500002 after the edge. No step_right before the next frame_tick, then exactly one step_right pulse.
- Bounce: toggle in_up every 1000 cycles for 50 toggles, then hold low -> lvl_up stays 0 and step_up never asserts.
- Hold in_left for 40 frames (DEBOUNCE_CYCLES=4 for speed) -> step_left at frames 1, 21, 25, 29, 33, 37 after lvl_left rises: 6 pulses, each 1 cycle wide.
- Hold in_up, then press in_down while up is repeating -> once both levels are 1, no step_up/step_down. Release down -> step_up resumes via FIRST (one frame later), then waits the full 20-frame delay.
- Hold in_up and in_right together -> step_up and step_right pulse in the same cycles. any_pressed=1 throughout.
- Assert rst mid-REPEAT with in_left held -> all outputs 0 immediately. After release, the FSM restarts from IDLE: debounce runs again, then the first strobe and the full repeat delay follow.
